// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop, ACK check.
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out byte once before reporting failure.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  state_e           state_q;
  logic             clk_s1_q, clk_s2_q, clk_prev_q;
  logic             data_s1_q, data_s2_q;
  logic [9:0]       shift_q;
  logic [3:0]       bit_cnt_q;
  logic [INH_W-1:0] inh_cnt_q;
  logic [TMO_W-1:0] tmo_q;
  logic             ack_q;
  logic             busy_q, done_q, ack_ok_q, clk_dl_q, data_dl_q;
`ifdef PS2_TX_RETRY_EN
  logic [7:0]       data_q;
  logic             retry_used_q;
`endif

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  logic fall_edge, tmo_run, timeout_hit, line_idle, end_attempt, attempt_ok;

  assign fall_edge   = clk_prev_q & ~clk_s2_q;
  assign tmo_run     = state_q inside {S_SEND, S_ACK, S_WAIT_IDLE};
  // An edge arriving in the expiry cycle wins over the timeout.
  assign timeout_hit = tmo_run && !fall_edge && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign line_idle   = (state_q == S_WAIT_IDLE) && clk_s2_q && data_s2_q;
  assign end_attempt = timeout_hit | line_idle;
  assign attempt_ok  = line_idle & ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      clk_prev_q   <= 1'b1;
      data_s1_q    <= 1'b1;
      data_s2_q    <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      inh_cnt_q    <= '0;
      tmo_q        <= '0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ack_ok_q     <= 1'b0;
      clk_dl_q     <= 1'b0;
      data_dl_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      data_q       <= '0;
      retry_used_q <= 1'b0;
`endif
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (tx_start) begin
            shift_q      <= frame_of(tx_data);
            bit_cnt_q    <= '0;
            inh_cnt_q    <= '0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b1;
            clk_dl_q     <= 1'b1;
            data_dl_q    <= 1'b0;
            state_q      <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
            data_q       <= tx_data;
            retry_used_q <= 1'b0;
`endif
          end
        end
        S_INHIBIT: begin
          if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
            data_dl_q <= 1'b1;
            state_q   <= S_REQ;
          end else begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
          end
        end
        S_REQ: begin
          clk_dl_q <= 1'b0;
          tmo_q    <= '0;
          state_q  <= S_SEND;
        end
        S_SEND: begin
          if (fall_edge) begin
            data_dl_q <= ~shift_q[0];
            shift_q   <= {1'b1, shift_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            tmo_q     <= '0;
            if (bit_cnt_q == 4'd9) state_q <= S_ACK;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_ACK: begin
          if (fall_edge) begin
            ack_q   <= ~data_s2_q;
            tmo_q   <= '0;
            state_q <= S_WAIT_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (fall_edge) tmo_q <= '0;
          else           tmo_q <= tmo_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase

      // Attempt completion overrides the per-state updates above.
      if (end_attempt) begin
`ifdef PS2_TX_RETRY_EN
        if (!attempt_ok && !retry_used_q) begin
          retry_used_q <= 1'b1;
          shift_q      <= frame_of(data_q);
          bit_cnt_q    <= '0;
          inh_cnt_q    <= '0;
          ack_q        <= 1'b0;
          clk_dl_q     <= 1'b1;
          data_dl_q    <= 1'b0;
          state_q      <= S_INHIBIT;
        end else
`endif
        begin
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          ack_ok_q  <= attempt_ok;
          clk_dl_q  <= 1'b0;
          data_dl_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      end
    end
  end

  assign tx_busy            = busy_q;
  assign tx_done            = done_q;
  assign tx_ack_ok          = ack_ok_q;
  assign ps2_clk_drive_low  = clk_dl_q;
  assign ps2_data_drive_low = data_dl_q;

endmodule
